sigmoid_mac_sequencer: RTL and testbench
========================================

Name: sigmoid_mac_sequencer

Overview:
- Sequences the shared sigmoid ALU multiplier: s3.0 signed × 1.3 unsigned → s4.3 product.
- Accepts a stream of L operand pairs on a valid/ready interface and drives each pair into the external combinational multiplier.
- Registers each product and accumulates the products into a signed fixed-point dot product (3 fractional bits).
- Returns the sum on a valid/ready result interface; sits between the layer controller and the sigmoid lookup stage.

Parameters:
- MAX_TERMS, 16, maximum dot-product length L.
- ACC_W, 12, accumulator/result width, format s(ACC_W-4).3.
- LEN_W, 5, width of len_in; must satisfy 2^LEN_W > MAX_TERMS.

Ports:
- clk  in  1  system clock; rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  start a dot product; sampled only in IDLE.
- len_in  in  LEN_W  term count L, latched on start; values above MAX_TERMS are clamped to MAX_TERMS.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts operand pair.
- in_signval  in  4  signed s3.0 operand.
- in_unsignval  in  4  unsigned 1.3 operand.
- mult_signval  out  4  to multiplier signval.
- mult_unsignval  out  4  to multiplier unsignval.
- mult_out  in  8  multiplier product, s4.3, combinational from mult_* outputs.
- result  out  ACC_W  accumulated sum, s(ACC_W-4).3.
- result_valid  out  1  result available.
- result_ready  in  1  consumer takes result.
- overflow  out  1  saturation occurred during this dot product; valid with result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, result=0, result_valid=0, overflow=0, busy=0, count=0, prod_vld=0.
- rst overrides everything, including mid-RUN or DONE; a partial sum is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with clamped L=0 → DONE with acc=0, overflow=0.
  - start=1 with L>0 → latch L, clear acc, count and overflow; go to RUN.
  - start outside IDLE is ignored.
- RUN:
  - in_ready=1.
  - A beat is accepted on the edge where in_valid&&in_ready.
  - mult_signval/mult_unsignval = in_signval/in_unsignval while in_ready=1, else 4'b0.
  - On accept: prod_q←mult_out, prod_vld←1, count←count+1. Otherwise prod_vld←0.
  - When the accepted beat makes count==L → DRAIN.
  - Input gaps (in_valid=0) stall with no side effects.
- Accumulation:
  - Each cycle prod_vld=1: acc←sat(acc + sign_extend(prod_q, ACC_W)).
  - Sum computed at ACC_W+1 bits. If it exceeds 2^(ACC_W-1)-1 or falls below -2^(ACC_W-1), clamp to that bound and set overflow (sticky until next start).
  - Default widths cannot overflow (|sum| ≤ 1920); saturation matters only for smaller ACC_W.
- DRAIN:
  - in_ready=0.
  - The final product is accumulated on this cycle's edge → DONE.
- DONE:
  - result=acc and result_valid=1, both held stable until result_ready=1.
  - On the handshake edge: result_valid←0 → IDLE.
  - A new start cannot be accepted on that same edge.
- Latency: last beat accepted in cycle c → DRAIN in c+1 → result_valid=1 in c+2.
- Throughput: one beat per cycle.
- mult_out is used only when in_ready=1; its value is otherwise ignored.

Test Plan:
- L=3, back-to-back beats (2,8),(−3,4),(7,15) = products 16,−12,105 → result=109 (13.625), overflow=0, result_valid exactly 2 cycles after the 3rd accept.
- Same L=3 stream with in_valid low for 2 cycles between beats → same result 109; in_ready stays 1 through the gaps; count unchanged.
- L=16, all beats (−8,15) → result=−1920; L=0 → DONE the cycle after start, result=0, no beats accepted.
- ACC_W=8 build, L=3, all beats (7,15) → result=127, overflow=1; the next start clears overflow.
- result_ready held low 5 cycles in DONE → result/result_valid stable, start pulses ignored; release → IDLE next cycle.
- rst asserted after 2 of 4 beats → all outputs at reset values next cycle; new start with L=1, beat (1,8) → result=8.

Source files
------------

// File: rtl/sigmoid_mac_sequencer.sv
// Feeds a stream of operand pairs through the shared sigmoid ALU multiplier and
// accumulates the s4.3 products into a saturating s(ACC_W-4).3 dot product.
module sigmoid_mac_sequencer #(
  parameter int MAX_TERMS = 16,
  parameter int ACC_W     = 12,
  parameter int LEN_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_signval,
  input  logic [3:0]       in_unsignval,
  output logic [3:0]       mult_signval,
  output logic [3:0]       mult_unsignval,
  input  logic [7:0]       mult_out,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, count, len_clamped;
  logic [7:0]       prod_q;
  logic             prod_vld;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic             accept;
  logic             last_beat;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;

  assign len_clamped = (len_in > LEN_W'(MAX_TERMS)) ? LEN_W'(MAX_TERMS) : len_in;

  assign in_ready       = (state == RUN);
  assign accept         = in_valid && in_ready;
  assign last_beat      = accept && ((count + LEN_W'(1)) == len_q);
  assign mult_signval   = in_ready ? in_signval   : 4'b0;
  assign mult_unsignval = in_ready ? in_unsignval : 4'b0;

  assign result       = acc;
  assign result_valid = (state == DONE);
  assign overflow     = ovf_q;
  assign busy         = (state != IDLE);

  // One guard bit is enough: a sign change between the top two bits means the
  // sum left the ACC_W range and must be clamped toward the original sign.
  assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W-7){prod_q[7]}}, prod_q};
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_sat = !sum_ovf   ? sum[ACC_W-1:0] :
                   sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                {1'b0, {(ACC_W-1){1'b1}}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order of statements or blocks.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_clamped == '0) ? DONE : RUN;
      RUN:     if (last_beat) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      count    <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod_q <= mult_out;
        count  <= count + LEN_W'(1);
      end
      if (state == IDLE && start) begin
        len_q <= len_clamped;
        count <= '0;
        acc   <= '0;
        ovf_q <= 1'b0;
      end else if (prod_vld) begin
        acc <= sum_sat;
        if (sum_ovf) ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_mac_sequencer.sv
// Randomized bench for sigmoid_mac_sequencer: a default build and an ACC_W=8
// build share stimulus and are compared against an integer dot-product model.
module tb_sigmoid_mac_sequencer;

  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len_in;
  logic             in_valid;
  logic [3:0]       in_signval, in_unsignval;
  logic             result_ready;

  logic        in_ready_a, result_valid_a, overflow_a, busy_a;
  logic [3:0]  msv_a, muv_a;
  logic [7:0]  mout_a;
  logic [11:0] result_a;

  logic        in_ready_b, result_valid_b, overflow_b, busy_b;
  logic [3:0]  msv_b, muv_b;
  logic [7:0]  mout_b;
  logic [7:0]  result_b;

  int n_tests = 0;
  int n_fail  = 0;
  int bs[$];
  int bu[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] mul(logic [3:0] s, logic [3:0] u);
    int r;
    r = int'($signed(s)) * int'(u);
    return r[7:0];
  endfunction

  assign mout_a = mul(msv_a, muv_a);
  assign mout_b = mul(msv_b, muv_b);

  sigmoid_mac_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start), .len_in(len_in),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_signval(in_signval), .in_unsignval(in_unsignval),
    .mult_signval(msv_a), .mult_unsignval(muv_a), .mult_out(mout_a),
    .result(result_a), .result_valid(result_valid_a), .result_ready(result_ready),
    .overflow(overflow_a), .busy(busy_a)
  );

  sigmoid_mac_sequencer #(.ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len_in(len_in),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_signval(in_signval), .in_unsignval(in_unsignval),
    .mult_signval(msv_b), .mult_unsignval(muv_b), .mult_out(mout_b),
    .result(result_b), .result_valid(result_valid_b), .result_ready(result_ready),
    .overflow(overflow_b), .busy(busy_b)
  );

  task automatic check(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer dot product, clamped to a w-bit signed range after each term.
  function automatic int model_sum(int w, output bit ov);
    int acc, hi, lo;
    acc = 0; ov = 0;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    foreach (bs[i]) begin
      acc += bs[i] * bu[i];
      if (acc > hi) begin acc = hi; ov = 1; end
      if (acc < lo) begin acc = lo; ov = 1; end
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(string tag);
    int ea, eb;
    bit oa, ob;
    ea = model_sum(12, oa);
    eb = model_sum(8, ob);
    check({tag, "_res12"}, 32'($signed(result_a)), ea);
    check({tag, "_ovf12"}, 32'(overflow_a), 32'(oa));
    check({tag, "_res8"},  32'($signed(result_b)), eb);
    check({tag, "_ovf8"},  32'(overflow_b), 32'(ob));
  endtask

  // Runs one dot product of length len (queued beats bs/bu, clamped length),
  // with random input gaps and a DONE hold of `hold` cycles.
  task automatic run_txn(string tag, int len, int gap_pct, int hold);
    int n, idx, cyc;
    logic [11:0] held;
    n = (len > 16) ? 16 : len;
    start = 1'b1; len_in = LEN_W'(len);
    tick();
    start = 1'b0;
    check({tag, "_ovf_clr"}, 32'(overflow_a | overflow_b), 0);
    if (n == 0) begin
      check({tag, "_l0_valid"}, 32'(result_valid_a), 1);
      check({tag, "_l0_ready"}, 32'(in_ready_a), 0);
    end else begin
      idx = 0; cyc = 0;
      while (idx < n && cyc < 500) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_signval = 4'(bs[idx]); in_unsignval = 4'(bu[idx]);
        check({tag, "_in_ready"}, 32'(in_ready_a & in_ready_b), 1);
        tick();
        if (in_valid) idx++;
        in_valid = 1'b0;
        cyc++;
      end
      if (cyc >= 500) check({tag, "_timeout"}, cyc, n);
      check({tag, "_drain_ready"}, 32'(in_ready_a), 0);
      check({tag, "_drain_valid"}, 32'(result_valid_a), 0);
      tick();
      check({tag, "_latency"}, 32'(result_valid_a & result_valid_b), 1);
    end
    check_results(tag);
    held = result_a;
    for (int i = 0; i < hold; i++) begin
      start = $urandom_range(1);
      len_in = LEN_W'($urandom_range(31));
      tick();
      check({tag, "_hold"}, 32'({result_valid_a, result_a}), 32'({1'b1, held}));
    end
    start = 1'b0; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_release"}, 32'({result_valid_a, busy_a, busy_b}), 0);
  endtask

  task automatic load(int len, int s, int u);
    bs.delete(); bu.delete();
    for (int i = 0; i < len && i < 16; i++) begin
      bs.push_back(s); bu.push_back(u);
    end
  endtask

  task automatic load_random(int len);
    bs.delete(); bu.delete();
    for (int i = 0; i < len && i < 16; i++) begin
      bs.push_back($urandom_range(15) - 8);
      bu.push_back($urandom_range(15));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; len_in = '0; in_valid = 1'b0;
    in_signval = '0; in_unsignval = '0; result_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outs", 32'({in_ready_a, result_valid_a, overflow_a, busy_a, result_a}), 0);

    bs = '{2, -3, 7}; bu = '{8, 4, 15};
    run_txn("l3_b2b", 3, 0, 0);
    check("l3_value", 32'($signed(result_a)), 109);
    run_txn("l3_gaps", 3, 60, 1);

    load(16, -8, 15);
    run_txn("l16_min", 16, 0, 2);
    load(0, 0, 0);
    run_txn("l0", 0, 0, 0);

    load(3, 7, 15);
    run_txn("sat8", 3, 0, 0);
    check("sat8_ovf", 32'(overflow_b), 1);
    load(1, 1, 8);
    run_txn("ovf_clear", 1, 0, 0);

    load_random(5);
    run_txn("hold5", 5, 20, 5);

    // Reset mid-RUN after 2 of 4 beats must discard the partial sum.
    start = 1'b1; len_in = 5'd4;
    tick();
    start = 1'b0; in_valid = 1'b1; in_signval = 4'd7; in_unsignval = 4'd15;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outs", 32'({in_ready_a, result_valid_a, overflow_a, busy_a, result_a}), 0);
    check("rst_mid_b", 32'({in_ready_b, result_valid_b, overflow_b, busy_b, result_b}), 0);
    load(1, 1, 8);
    run_txn("after_rst", 1, 0, 0);
    check("after_rst_val", 32'($signed(result_a)), 8);

    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(20);
      load_random(len);
      run_txn("rand", len, $urandom_range(50), $urandom_range(3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
